// File: rtl/guess_round_ctrl.sv
// rtl/guess_round_ctrl.sv - round sequencer for the guessing game (optional hints via GUESS_HINT_EN)
module guess_round_ctrl #(
  parameter int T_LVL1 = 30,
  parameter int T_LVL2 = 60,
  parameter int T_LVL3 = 90,
  parameter int ROUNDS = 5
) (
  input  logic       clk,
  input  logic       restart_n,
  input  logic       tick_1hz,
  input  logic       confirm,
  input  logic [9:0] guess,
  input  logic [1:0] level,
  input  logic [9:0] target,
  input  logic       target_valid,
  output logic       new_target,
  output logic [6:0] timer,
  output logic [2:0] round,
  output logic [2:0] incorrect_guesses,
  output logic       guess_correct,
  output logic       guess_wrong,
  output logic       timeout,
  output logic       busy
`ifdef GUESS_HINT_EN
  ,
  output logic       hint_high,
  output logic       hint_low
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_PLAY,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [6:0] BUDGET1 = 7'(T_LVL1);
  localparam logic [6:0] BUDGET2 = 7'(T_LVL2);
  localparam logic [6:0] BUDGET3 = 7'(T_LVL3);
  localparam logic [2:0] ROUNDS_W = 3'(ROUNDS);

  state_t     state, state_nx;
  logic [1:0] level_q;
  logic [9:0] target_q, target_nx;
  logic [9:0] guess_q, guess_nx;
  logic [6:0] timer_nx;
  logic [2:0] round_nx, incorrect_nx;
  logic       timeout_nx;
  logic       correct_nx, wrong_nx;
  logic       level_chg;
  logic       hit;
  logic [2:0] round_inc, incorrect_inc;
  logic [6:0] budget;
  logic [9:0] limit;

  assign level_chg     = (level != level_q);
  assign hit           = (guess_q == target_q);
  assign round_inc     = (round == 3'd7) ? 3'd7 : round + 3'd1;
  assign incorrect_inc = (incorrect_guesses == 3'd7) ? 3'd7 : incorrect_guesses + 3'd1;

  // Timer budget for the incoming level and guess range limit for the active level
  always_comb begin
    budget = 7'd0;
    limit  = 10'd0;
    case (level)
      2'd1:    budget = BUDGET1;
      2'd2:    budget = BUDGET2;
      2'd3:    budget = BUDGET3;
      default: budget = 7'd0;
    endcase
    case (level_q)
      2'd1:    limit = 10'd9;
      2'd2:    limit = 10'd99;
      2'd3:    limit = 10'd999;
      default: limit = 10'd0;
    endcase
  end

  // State and datapath register; busy/new_target are registered from the next state
  always_ff @(posedge clk or negedge restart_n) begin
    if (!restart_n) begin
      state             <= S_IDLE;
      level_q           <= 2'd0;
      target_q          <= 10'd0;
      guess_q           <= 10'd0;
      timer             <= 7'd0;
      round             <= 3'd0;
      incorrect_guesses <= 3'd0;
      timeout           <= 1'b0;
      guess_correct     <= 1'b0;
      guess_wrong       <= 1'b0;
      new_target        <= 1'b0;
      busy              <= 1'b0;
    end else begin
      state             <= state_nx;
      level_q           <= level;
      target_q          <= target_nx;
      guess_q           <= guess_nx;
      timer             <= timer_nx;
      round             <= round_nx;
      incorrect_guesses <= incorrect_nx;
      timeout           <= timeout_nx;
      guess_correct     <= correct_nx;
      guess_wrong       <= wrong_nx;
      new_target        <= (state_nx == S_REQ);
      busy              <= (state_nx == S_REQ) || (state_nx == S_PLAY) || (state_nx == S_CHECK);
    end
  end

  // Next-state and counter update; a level change overrides every other event
  always_comb begin
    state_nx     = state;
    target_nx    = target_q;
    guess_nx     = guess_q;
    timer_nx     = timer;
    round_nx     = round;
    incorrect_nx = incorrect_guesses;
    timeout_nx   = timeout;
    correct_nx   = 1'b0;
    wrong_nx     = 1'b0;
    if (level_chg) begin
      if (level != 2'd0) begin
        state_nx     = S_REQ;
        timer_nx     = budget;
        round_nx     = 3'd0;
        incorrect_nx = 3'd0;
        timeout_nx   = 1'b0;
      end else begin
        state_nx = S_IDLE;
      end
    end else begin
      if (tick_1hz && (timer != 7'd0) &&
          ((state == S_REQ) || (state == S_PLAY) || (state == S_CHECK))) begin
        timer_nx = timer - 7'd1;
      end
      case (state)
        S_REQ: begin
          if (target_valid) begin
            target_nx = target;
            state_nx  = S_PLAY;
          end
        end
        S_PLAY: begin
          if (timer == 7'd0) begin
            state_nx   = S_DONE;
            timeout_nx = 1'b1;
          end else if (confirm && (guess <= limit)) begin
            guess_nx = guess;
            state_nx = S_CHECK;
          end
        end
        S_CHECK: begin
          if (hit) begin
            correct_nx = 1'b1;
            round_nx   = round_inc;
          end else begin
            wrong_nx     = 1'b1;
            incorrect_nx = incorrect_inc;
          end
          if (timer == 7'd0) begin
            state_nx   = S_DONE;
            timeout_nx = 1'b1;
          end else if (hit && (round_inc == ROUNDS_W)) begin
            state_nx = S_DONE;
          end else if (hit) begin
            state_nx = S_REQ;
          end else begin
            state_nx = S_PLAY;
          end
        end
        default: state_nx = state;
      endcase
    end
  end

`ifdef GUESS_HINT_EN
  // Direction hints, updated in CHECK and cleared by any level change
  always_ff @(posedge clk or negedge restart_n) begin
    if (!restart_n) begin
      hint_high <= 1'b0;
      hint_low  <= 1'b0;
    end else if (level_chg) begin
      hint_high <= 1'b0;
      hint_low  <= 1'b0;
    end else if (state == S_CHECK) begin
      hint_high <= (guess_q > target_q);
      hint_low  <= (guess_q < target_q);
    end
  end
`endif

endmodule

// File: tb/tb_guess_round_ctrl.sv
// tb/tb_guess_round_ctrl.sv - directed testbench for guess_round_ctrl
module tb_guess_round_ctrl;

  logic       clk = 1'b0;
  logic       restart_n;
  logic       tick_1hz;
  logic       confirm;
  logic [9:0] guess;
  logic [1:0] level;
  logic [9:0] target;
  logic       target_valid;
  logic       new_target;
  logic [6:0] timer;
  logic [2:0] round;
  logic [2:0] incorrect_guesses;
  logic       guess_correct;
  logic       guess_wrong;
  logic       timeout;
  logic       busy;
`ifdef GUESS_HINT_EN
  logic       hint_high;
  logic       hint_low;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  guess_round_ctrl dut (
    .clk(clk),
    .restart_n(restart_n),
    .tick_1hz(tick_1hz),
    .confirm(confirm),
    .guess(guess),
    .level(level),
    .target(target),
    .target_valid(target_valid),
    .new_target(new_target),
    .timer(timer),
    .round(round),
    .incorrect_guesses(incorrect_guesses),
    .guess_correct(guess_correct),
    .guess_wrong(guess_wrong),
    .timeout(timeout),
    .busy(busy)
`ifdef GUESS_HINT_EN
    ,
    .hint_high(hint_high),
    .hint_low(hint_low)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    restart_n = 1'b0; tick_1hz = 0; confirm = 0; guess = 0; level = 0; target = 0; target_valid = 0;
    step();
    step();
    total_cnt++; if (timer !== 7'd0) $display("FAIL reset_timer: got %0d expected 0", timer); else pass_cnt++;
    total_cnt++; if (round !== 3'd0) $display("FAIL reset_round: got %0d expected 0", round); else pass_cnt++;
    total_cnt++; if (incorrect_guesses !== 3'd0) $display("FAIL reset_incorrect: got %0d expected 0", incorrect_guesses); else pass_cnt++;
    total_cnt++; if ({new_target, busy, timeout, guess_correct, guess_wrong} !== 5'b0)
      $display("FAIL reset_flags: got %b expected 00000", {new_target, busy, timeout, guess_correct, guess_wrong}); else pass_cnt++;
    restart_n = 1'b1;
    step();
  endtask

  task automatic test_level1_start();
    level = 2'd1;
    step();
    total_cnt++; if (timer !== 7'd30) $display("FAIL l1_timer: got %0d expected 30", timer); else pass_cnt++;
    total_cnt++; if (round !== 3'd0) $display("FAIL l1_round: got %0d expected 0", round); else pass_cnt++;
    total_cnt++; if (new_target !== 1'b1) $display("FAIL l1_new_target: got %b expected 1", new_target); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL l1_busy: got %b expected 1", busy); else pass_cnt++;
    target = 10'd7; target_valid = 1'b1;
    step();
    target_valid = 1'b0;
    total_cnt++; if (new_target !== 1'b0) $display("FAIL l1_req_exit: got %b expected 0", new_target); else pass_cnt++;
  endtask

  task automatic test_guesses();
    guess = 10'd3; confirm = 1'b1;
    step();
    confirm = 1'b0;
    total_cnt++; if (guess_wrong !== 1'b0) $display("FAIL wrong_early: got %b expected 0", guess_wrong); else pass_cnt++;
    step();
    total_cnt++; if (guess_wrong !== 1'b1) $display("FAIL wrong_pulse: got %b expected 1", guess_wrong); else pass_cnt++;
    total_cnt++; if (incorrect_guesses !== 3'd1) $display("FAIL wrong_count: got %0d expected 1", incorrect_guesses); else pass_cnt++;
    guess = 10'd42; confirm = 1'b1;
    step();
    confirm = 1'b0;
    step();
    total_cnt++; if ({guess_correct, guess_wrong} !== 2'b00) $display("FAIL out_of_range_pulse: got %b expected 00", {guess_correct, guess_wrong}); else pass_cnt++;
    total_cnt++; if (incorrect_guesses !== 3'd1) $display("FAIL out_of_range_count: got %0d expected 1", incorrect_guesses); else pass_cnt++;
    guess = 10'd7; confirm = 1'b1;
    step();
    confirm = 1'b0;
    step();
    total_cnt++; if (guess_correct !== 1'b1) $display("FAIL correct_pulse: got %b expected 1", guess_correct); else pass_cnt++;
    total_cnt++; if (round !== 3'd1) $display("FAIL correct_round: got %0d expected 1", round); else pass_cnt++;
    total_cnt++; if (new_target !== 1'b1) $display("FAIL back_to_req: got %b expected 1", new_target); else pass_cnt++;
  endtask

  task automatic test_level2_rounds();
    level = 2'd2;
    step();
    total_cnt++; if (timer !== 7'd60) $display("FAIL l2_timer: got %0d expected 60", timer); else pass_cnt++;
    total_cnt++; if (incorrect_guesses !== 3'd0) $display("FAIL l2_clear: got %0d expected 0", incorrect_guesses); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      target = 10'(50 + i); target_valid = 1'b1;
      step();
      target_valid = 1'b0;
      guess = 10'(50 + i); confirm = 1'b1;
      step();
      confirm = 1'b0;
      step();
      total_cnt++; if (guess_correct !== 1'b1) $display("FAIL l2_correct_%0d: got %b expected 1", i, guess_correct); else pass_cnt++;
    end
    total_cnt++; if (round !== 3'd5) $display("FAIL l2_round: got %0d expected 5", round); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL l2_done_busy: got %b expected 0", busy); else pass_cnt++;
    guess = 10'd54; confirm = 1'b1;
    step();
    confirm = 1'b0;
    step();
    total_cnt++; if (round !== 3'd5) $display("FAIL done_confirm_ignored: got %0d expected 5", round); else pass_cnt++;
    level = 2'd3;
    step();
    total_cnt++; if (timer !== 7'd90) $display("FAIL l3_timer: got %0d expected 90", timer); else pass_cnt++;
    total_cnt++; if (round !== 3'd0) $display("FAIL l3_round: got %0d expected 0", round); else pass_cnt++;
  endtask

  task automatic test_timeout();
    level = 2'd1;
    step();
    target = 10'd4; target_valid = 1'b1;
    step();
    target_valid = 1'b0;
    tick_1hz = 1'b1;
    for (int i = 0; i < 30; i++) step();
    tick_1hz = 1'b0;
    total_cnt++; if (timer !== 7'd0) $display("FAIL to_timer_zero: got %0d expected 0", timer); else pass_cnt++;
    total_cnt++; if (timeout !== 1'b0) $display("FAIL to_not_yet: got %b expected 0", timeout); else pass_cnt++;
    step();
    total_cnt++; if (timeout !== 1'b1) $display("FAIL to_set: got %b expected 1", timeout); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL to_busy: got %b expected 0", busy); else pass_cnt++;
    tick_1hz = 1'b1; confirm = 1'b1; guess = 10'd4;
    for (int i = 0; i < 4; i++) step();
    tick_1hz = 1'b0; confirm = 1'b0;
    step();
    total_cnt++; if ({timeout, timer, round} !== {1'b1, 7'd0, 3'd0})
      $display("FAIL to_hold: got timeout=%b timer=%0d round=%0d expected 1/0/0", timeout, timer, round); else pass_cnt++;
  endtask

  task automatic test_expiry_with_guess();
    level = 2'd2;
    step();
    target = 10'd5; target_valid = 1'b1;
    step();
    target_valid = 1'b0;
    tick_1hz = 1'b1;
    for (int i = 0; i < 59; i++) step();
    total_cnt++; if (timer !== 7'd1) $display("FAIL exp_timer_one: got %0d expected 1", timer); else pass_cnt++;
    guess = 10'd5; confirm = 1'b1;
    step();
    tick_1hz = 1'b0; confirm = 1'b0;
    step();
    total_cnt++; if (guess_correct !== 1'b1) $display("FAIL exp_correct: got %b expected 1", guess_correct); else pass_cnt++;
    total_cnt++; if (round !== 3'd1) $display("FAIL exp_round: got %0d expected 1", round); else pass_cnt++;
    total_cnt++; if (timeout !== 1'b1) $display("FAIL exp_timeout: got %b expected 1", timeout); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL exp_done: got %b expected 0", busy); else pass_cnt++;
  endtask

  task automatic test_restart_in_check();
    level = 2'd3;
    step();
    target = 10'd500; target_valid = 1'b1;
    step();
    target_valid = 1'b0;
    guess = 10'd400; confirm = 1'b1;
    step();
    confirm = 1'b0;
    level = 2'd0;
    #2;
    restart_n = 1'b0;
    #1;
    total_cnt++; if ({timer, round, incorrect_guesses} !== 13'd0)
      $display("FAIL rst_counters: got timer=%0d round=%0d inc=%0d expected 0", timer, round, incorrect_guesses); else pass_cnt++;
    total_cnt++; if ({new_target, busy, timeout, guess_correct, guess_wrong} !== 5'b0)
      $display("FAIL rst_flags: got %b expected 00000", {new_target, busy, timeout, guess_correct, guess_wrong}); else pass_cnt++;
    step();
    restart_n = 1'b1;
    step();
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_idle: got %b expected 0", busy); else pass_cnt++;
  endtask

`ifdef GUESS_HINT_EN
  task automatic test_hint();
    level = 2'd1;
    step();
    target = 10'd7; target_valid = 1'b1;
    step();
    target_valid = 1'b0;
    guess = 10'd2; confirm = 1'b1;
    step();
    confirm = 1'b0;
    step();
    total_cnt++; if ({hint_low, hint_high, guess_wrong} !== 3'b101)
      $display("FAIL hint_low: got low=%b high=%b wrong=%b expected 1/0/1", hint_low, hint_high, guess_wrong); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_level1_start();
    test_guesses();
    test_level2_rounds();
    test_timeout();
    test_expiry_with_guess();
    test_restart_in_check();
`ifdef GUESS_HINT_EN
    test_hint();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
